// File: rtl/product_accumulator.sv
// Sums groups of up to NTERMS unsigned products from a multiplier stream and presents each
// group sum with its term count over a valid/ready output handshake.
module product_accumulator #(
  parameter int unsigned NBITS  = 8,
  parameter int unsigned NTERMS = 4,
  parameter int unsigned ACCW   = 2 * NBITS + $clog2(NTERMS + 1)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [2*NBITS-1:0]           product,
  input  logic                         iValid,
  input  logic                         iLast,
  output logic                         iReady,
  output logic [ACCW-1:0]              sum,
  output logic [$clog2(NTERMS+1)-1:0]  terms,
  output logic                         oValid,
  input  logic                         oReady
);

  localparam int unsigned CNTW = $clog2(NTERMS + 1);

  typedef enum logic {StAcc, StHold} state_e;

  state_e          r_state;
  logic [ACCW-1:0] r_acc;
  logic [CNTW-1:0] r_cnt;
  logic [ACCW-1:0] r_sum;
  logic [CNTW-1:0] r_terms;
  logic            r_iready;
  logic            r_ovalid;

  logic            w_accept;
  logic            w_group_end;
  logic [ACCW-1:0] w_acc_next;
  logic [CNTW-1:0] w_cnt_next;

  assign w_accept    = iValid && r_iready;
  assign w_acc_next  = r_acc + ACCW'(product);
  assign w_cnt_next  = r_cnt + CNTW'(1);
  assign w_group_end = w_accept && (iLast || (w_cnt_next == CNTW'(NTERMS)));

  // r_iready starts at 0 so the block refuses input until the first edge after reset release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= StAcc;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_sum    <= '0;
      r_terms  <= '0;
      r_iready <= 1'b0;
      r_ovalid <= 1'b0;
    end else begin
      case (r_state)
        StAcc: begin
          r_iready <= 1'b1;
          if (w_group_end) begin
            r_sum    <= w_acc_next;
            r_terms  <= w_cnt_next;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= StHold;
            r_iready <= 1'b0;
            r_ovalid <= 1'b1;
          end else if (w_accept) begin
            r_acc <= w_acc_next;
            r_cnt <= w_cnt_next;
          end
        end
        StHold: begin
          if (oReady) begin
            r_state  <= StAcc;
            r_iready <= 1'b1;
            r_ovalid <= 1'b0;
          end
        end
        default: begin
          r_state  <= StAcc;
          r_iready <= 1'b0;
          r_ovalid <= 1'b0;
        end
      endcase
    end
  end

  assign iReady = r_iready;
  assign oValid = r_ovalid;
  assign sum    = r_sum;
  assign terms  = r_terms;

endmodule
